// File: rtl/usb_fs_tx.sv
// ---------------------------------------------------------------------------
// UsbFsTx : USB full-speed packet transmitter (SYNC, NRZI, bit stuffing, EOP)
//
// Parameters
//   CLK_PER_BIT : clk48 cycles per full-speed bit (48 MHz / 12 Mbps = 4)
//
// Ports
//   clk48    in   system clock
//   rst_n    in   asynchronous active-low reset
//   tx_valid in   a packet byte is offered on tx_data
//   tx_data  in   packet byte (PID first), sent LSB first
//   tx_last  in   tx_data is the final byte of the packet
//   tx_ready out  one-cycle pulse; tx_data/tx_last are taken at the edge
//                 that ends this cycle when tx_valid is high
//   usb_dp   out  D+ drive value
//   usb_dn   out  D- drive value
//   usb_oe   out  pad output enable
//   busy     out  high from packet start until usb_oe falls
//   underrun out  one-cycle pulse when a non-last byte is missing at its
//                 tx_ready cycle; it is registered at the edge that ends
//                 the starved tx_ready cycle, so it coincides with the
//                 first SE0 cycle
// ---------------------------------------------------------------------------
module usb_fs_tx #(
    parameter int CLK_PER_BIT = 4
) (
    input  logic       clk48,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       usb_dp,
    output logic       usb_dn,
    output logic       usb_oe,
    output logic       busy,
    output logic       underrun
);

    localparam int PW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [PW-1:0] LAST_PHASE = PW'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP_SE0,
        EOP_J
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [2:0]    bitCnt_q, bitCnt_d;
    logic [2:0]    onesCnt_q, onesCnt_d;
    logic [6:0]    shift_q, shift_d;
    logic          lastByte_q, lastByte_d;
    logic          lineJ_q, lineJ_d;
    logic          dp_q, dp_d;
    logic          dn_q, dn_d;
    logic          oe_q, oe_d;
    logic          busy_q, busy_d;
    logic          txReady_q, txReady_d;
    logic          underrun_q, underrun_d;

    logic          lastPhase;
    logic          sendEn;
    logic          sendBit;
    logic          byteEnd;

    // Next-state logic. Every bit decision is made at the edge that ends the
    // current bit (lastPhase), so the new line level is registered directly.
    // bitCnt_q indexes the bit on the line; shift_q holds the bits of the
    // current byte that have not been sent yet, next one in bit 0.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bitCnt_d   = bitCnt_q;
        onesCnt_d  = onesCnt_q;
        shift_d    = shift_q;
        lastByte_d = lastByte_q;
        lineJ_d    = lineJ_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        underrun_d = 1'b0;
        sendEn     = 1'b0;
        sendBit    = 1'b0;
        byteEnd    = 1'b0;

        lastPhase = (phase_q == LAST_PHASE);
        if (state_q != IDLE) begin
            phase_d = lastPhase ? '0 : phase_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (tx_valid) begin
                    // First SYNC bit is a 0: the line toggles from J to K.
                    state_d    = SYNC;
                    bitCnt_d   = 3'd0;
                    onesCnt_d  = 3'd0;
                    lastByte_d = 1'b0;
                    lineJ_d    = 1'b0;
                    oe_d       = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            SYNC: begin
                if (lastPhase) begin
                    if (bitCnt_q != 3'd7) begin
                        bitCnt_d = bitCnt_q + 3'd1;
                        sendEn   = 1'b1;
                        sendBit  = (bitCnt_q == 3'd6);
                    end else begin
                        byteEnd = 1'b1;
                    end
                end
            end
            DATA: begin
                if (lastPhase) begin
                    if (onesCnt_q == 3'd6) begin
                        // Stuffed 0; the data position does not advance.
                        sendEn  = 1'b1;
                        sendBit = 1'b0;
                    end else if (bitCnt_q == 3'd7) begin
                        byteEnd = 1'b1;
                    end else begin
                        bitCnt_d = bitCnt_q + 3'd1;
                        sendEn   = 1'b1;
                        sendBit  = shift_q[0];
                        shift_d  = {1'b0, shift_q[6:1]};
                    end
                end
            end
            EOP_SE0: begin
                if (lastPhase) begin
                    if (bitCnt_q == 3'd1) begin
                        state_d  = EOP_J;
                        bitCnt_d = 3'd0;
                        lineJ_d  = 1'b1;
                    end else begin
                        bitCnt_d = bitCnt_q + 3'd1;
                    end
                end
            end
            EOP_J: begin
                if (lastPhase) begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                    busy_d  = 1'b0;
                    lineJ_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A byte boundary either loads the offered byte or ends the packet.
        // txReady_q is low here only when the previous byte was the last one.
        if (byteEnd) begin
            bitCnt_d = 3'd0;
            if (txReady_q && tx_valid) begin
                state_d    = DATA;
                shift_d    = tx_data[7:1];
                lastByte_d = tx_last;
                sendEn     = 1'b1;
                sendBit    = tx_data[0];
            end else begin
                underrun_d = txReady_q;
                state_d    = EOP_SE0;
            end
        end

        // NRZI: a 0 toggles the line, a 1 holds it and extends the ones run.
        if (sendEn) begin
            onesCnt_d = sendBit ? onesCnt_q + 3'd1 : 3'd0;
            lineJ_d   = sendBit ? lineJ_q : ~lineJ_q;
        end

        dp_d = (state_d == EOP_SE0) ? 1'b0 : lineJ_d;
        dn_d = (state_d == EOP_SE0) ? 1'b0 : ~lineJ_d;

        // Ready is raised for the final cycle of the bit that precedes a
        // byte: last SYNC bit, bit 7 with no stuff pending, or that stuff bit.
        txReady_d = (phase_d == LAST_PHASE) &&
                    (((state_d == SYNC) && (bitCnt_d == 3'd7)) ||
                     ((state_d == DATA) && (bitCnt_d == 3'd7) &&
                      (onesCnt_d != 3'd6) && !lastByte_d));
    end

    // All state and outputs registered; reset leaves the line at J, undriven.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            bitCnt_q   <= 3'd0;
            onesCnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            lastByte_q <= 1'b0;
            lineJ_q    <= 1'b1;
            dp_q       <= 1'b1;
            dn_q       <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            txReady_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bitCnt_q   <= bitCnt_d;
            onesCnt_q  <= onesCnt_d;
            shift_q    <= shift_d;
            lastByte_q <= lastByte_d;
            lineJ_q    <= lineJ_d;
            dp_q       <= dp_d;
            dn_q       <= dn_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            txReady_q  <= txReady_d;
            underrun_q <= underrun_d;
        end
    end

    assign tx_ready = txReady_q;
    assign usb_dp   = dp_q;
    assign usb_dn   = dn_q;
    assign usb_oe   = oe_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_usb_fs_tx.sv
// ---------------------------------------------------------------------------
// TbUsbFsTx : bench for usb_fs_tx. A packet-level model turns the byte list
// into a bit list (SYNC, data, stuffing), NRZI-encodes it and expands every
// symbol to CPB cycles; the DUT outputs are compared cycle by cycle.
// ---------------------------------------------------------------------------
module tb_usb_fs_tx;

    localparam int CPB = 4;

    typedef logic [7:0] byteQ_t[$];

    logic       clk48 = 1'b0;
    logic       rst_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       usb_dp;
    logic       usb_dn;
    logic       usb_oe;
    logic       busy;
    logic       underrun;

    int testsRun = 0;
    int testsFailed = 0;

    logic [1:0] lineSeq[$];
    int         readyCycles[$];
    int         underrunCycle;
    int         stuffCount;

    // {oe, busy, dp, dn, ready, underrun} when idle or in reset
    localparam logic [5:0] IDLE_VEC = 6'b001000;

    usb_fs_tx #(.CLK_PER_BIT(CPB)) dut (
        .clk48   (clk48),
        .rst_n   (rst_n),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .tx_last (tx_last),
        .tx_ready(tx_ready),
        .usb_dp  (usb_dp),
        .usb_dn  (usb_dn),
        .usb_oe  (usb_oe),
        .busy    (busy),
        .underrun(underrun)
    );

    // 48 MHz-style free-running clock
    always #5 clk48 = ~clk48;

    // One comparison: counts it, and on mismatch counts and reports it
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [5:0] outVec();
        return {usb_oe, busy, usb_dp, usb_dn, tx_ready, underrun};
    endfunction

    // Packet model: bit list with stuffing, NRZI line symbols, ready cycles
    task automatic buildModel(input byteQ_t bytes, input bit starve);
        bit q[$];
        int run;
        logic lvl;
        lineSeq.delete();
        readyCycles.delete();
        stuffCount = 0;
        q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        run = 1;
        foreach (bytes[k]) begin
            readyCycles.push_back(q.size() * CPB - 1);
            for (int i = 0; i < 8; i++) begin
                q.push_back(bytes[k][i]);
                run = bytes[k][i] ? run + 1 : 0;
                if (run == 6) begin
                    q.push_back(1'b0);
                    run = 0;
                    stuffCount++;
                end
            end
        end
        if (starve) begin
            readyCycles.push_back(q.size() * CPB - 1);
            underrunCycle = q.size() * CPB;
        end else begin
            underrunCycle = -1;
        end
        lvl = 1'b1;
        foreach (q[i]) begin
            if (!q[i]) lvl = ~lvl;
            lineSeq.push_back({lvl, ~lvl});
        end
        lineSeq.push_back(2'b00);
        lineSeq.push_back(2'b00);
        lineSeq.push_back(2'b10);
    endtask

    function automatic bit isReadyCycle(input int c);
        foreach (readyCycles[i]) if (readyCycles[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    // Sends one packet from IDLE and checks every cycle up to two idle cycles
    // after the end. expOe < 0 means use the usb_oe cycle-count formula.
    task automatic applyStimulus(input byteQ_t bytes, input bit starve,
                                 input int expOe, input string name);
        int total;
        int idx;
        bit advance;
        int oeCount;
        int readyCount;
        logic [5:0] expVec;
        buildModel(bytes, starve);
        total = lineSeq.size() * CPB;
        idx = 0;
        advance = 1'b0;
        oeCount = 0;
        readyCount = 0;
        tx_valid = 1'b1;
        tx_data  = bytes[0];
        tx_last  = !starve && (bytes.size() == 1);
        for (int c = 0; c <= total + 1; c++) begin
            @(posedge clk48);
            #1;
            if (advance) begin
                advance = 1'b0;
                idx++;
                if (idx < bytes.size()) begin
                    tx_data = bytes[idx];
                    tx_last = !starve && (idx == bytes.size() - 1);
                end else begin
                    tx_valid = 1'b0;
                    tx_data  = 8'h00;
                    tx_last  = 1'b0;
                end
            end
            if (c < total)
                expVec = {2'b11, lineSeq[c / CPB], isReadyCycle(c), (c == underrunCycle)};
            else
                expVec = IDLE_VEC;
            checkOutput($sformatf("%s cyc%0d {oe,busy,dp,dn,rdy,und}", name, c),
                        32'(outVec()), 32'(expVec));
            oeCount += int'(usb_oe);
            readyCount += int'(tx_ready);
            if (tx_ready && tx_valid) advance = 1'b1;
        end
        if (expOe < 0)
            expOe = CPB * (8 + 8 * bytes.size() + stuffCount + 3);
        checkOutput($sformatf("%s oe cycles", name), 32'(oeCount), 32'(expOe));
        checkOutput($sformatf("%s ready pulses", name), 32'(readyCount),
                    32'(readyCycles.size()));
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    initial begin
        byteQ_t pkt;
        int n;

        // Reset asserted asynchronously, away from any clock edge
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        #2 rst_n = 1'b0;
        #1 checkOutput("reset immediate", 32'(outVec()), 32'(IDLE_VEC));
        repeat (2) @(posedge clk48);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk48);
            #1 checkOutput($sformatf("idle after reset %0d", i), 32'(outVec()), 32'(IDLE_VEC));
        end

        // Directed packets
        pkt = '{8'h00};
        applyStimulus(pkt, 1'b0, 76, "byte00");
        pkt = '{8'hFF};
        applyStimulus(pkt, 1'b0, 80, "byteFF");
        pkt = '{8'hA5, 8'h3C};
        applyStimulus(pkt, 1'b0, 108, "A5_3C");
        pkt = '{8'h2D};
        applyStimulus(pkt, 1'b1, 76, "underrun2D");
        pkt = '{8'h7F, 8'hFF, 8'hFE};
        applyStimulus(pkt, 1'b0, -1, "stuffAcross");

        // Reset in the middle of DATA: no EOP, line back to idle J at once
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        tx_last  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk48);
            #1;
        end
        checkOutput("midpacket oe before reset", 32'(usb_oe), 32'd1);
        #2 rst_n = 1'b0;
        tx_valid = 1'b0;
        #1 checkOutput("midpacket reset immediate", 32'(outVec()), 32'(IDLE_VEC));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk48);
            #1 checkOutput($sformatf("held reset %0d", i), 32'(outVec()), 32'(IDLE_VEC));
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk48);
            #1 checkOutput($sformatf("idle after midreset %0d", i), 32'(outVec()), 32'(IDLE_VEC));
        end
        pkt = '{8'h00};
        applyStimulus(pkt, 1'b0, 76, "afterReset");

        // Randomized packets, including one starved packet
        for (int p = 0; p < 5; p++) begin
            pkt.delete();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
            applyStimulus(pkt, 1'b0, -1, $sformatf("rand%0d", p));
        end
        pkt.delete();
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
        applyStimulus(pkt, 1'b1, -1, "randStarve");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
